i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCL quarter-period; legal values are 2 or more.
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock, active on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: transaction request, sampled on clk.
REQ-005 The module SHALL have port addr, input, 7 bits: target slave address.
REQ-006 The module SHALL have port rw, input, 1 bit: 0 means write to the slave, 1 means read from the slave.
REQ-007 The module SHALL have port data_write_master, input, 8 bits: the byte sent on a write.
REQ-008 The module SHALL have port data_read_master, output, 8 bits: the byte received on a read.
REQ-009 The module SHALL have port busy, output, 1 bit: high while a transaction is in progress.
REQ-010 The module SHALL have port done, output, 1 bit: a one-clk pulse when a transaction completes.
REQ-011 The module SHALL have port ack_error, output, 1 bit: high when the slave did not acknowledge; holds until the next accepted start.
REQ-012 The module SHALL have port sda, inout, 1 bit: I2C data line, open-drain.
REQ-013 The module SHALL have port scl, inout, 1 bit: I2C clock line, open-drain.

Function
REQ-014 sda and scl SHALL only be driven 0 or released (z); external pull-ups supply the 1 level.
REQ-015 Start SHALL be accepted only in IDLE; on acceptance addr, rw and data_write_master SHALL be latched, and start SHALL be ignored while busy=1.
REQ-016 A quarter tick SHALL occur every CLK_DIV clk cycles; each bit period SHALL be 4 quarters:
- Q0: scl low, sda updated.
- Q1: scl released.
- Q2: scl high, sda sampled.
- Q3: scl pulled low.
REQ-017 The FSM SHALL run IDLE -> START -> ADDR -> ADDR_ACK -> (WRITE_DATA -> WRITE_ACK | READ_DATA -> READ_NACK) -> STOP -> IDLE.
REQ-018 START (one bit period) SHALL pull sda low while scl is released high, then pull scl low.
REQ-019 ADDR SHALL shift out {addr, rw} over 8 bit periods, MSB first.
REQ-020 ADDR_ACK SHALL release sda and sample it in Q2; a sampled 1 SHALL set ack_error and go directly to STOP.
REQ-021 WRITE_DATA SHALL shift out the latched byte, MSB first; WRITE_ACK SHALL sample as in ADDR_ACK, and a sampled 1 SHALL set ack_error; the next state is STOP in either case.
REQ-022 READ_DATA SHALL release sda and shift in 8 bits, MSB first, sampled in Q2; data_read_master SHALL update only at the end of the 8th bit.
REQ-023 READ_NACK SHALL hold sda released for one bit period (master NACK, single-byte read).
REQ-024 STOP SHALL hold sda low with scl low, release scl, then release sda while scl is high.
REQ-025 done SHALL pulse on the last clk of STOP; busy SHALL fall in the same cycle.
REQ-026 busy SHALL be 1 from the clk after start is accepted.
REQ-027 Latency from acceptance to done SHALL be 20*4*CLK_DIV clks for a full transaction and 11*4*CLK_DIV clks on an address NACK.
REQ-028 Clock stretching and multi-master arbitration SHALL NOT be supported; scl is not monitored.
REQ-029 sda SHALL change only while scl is low, except during START and STOP.

Reset
REQ-030 rst=1 SHALL immediately release sda and scl and force the state to IDLE.
REQ-031 rst=1 SHALL set busy=0, done=0, ack_error=0, data_read_master=8'h00 and clear the divider and bit counters.
REQ-032 rst asserted mid-transaction SHALL abort without generating a STOP; the bus is left released.

Verification
REQ-033 Write, CLK_DIV=4, with a slave model at address 7'h55 and pull-ups: addr=7'h55, rw=0, data=8'hA5, start pulse -> slave receives 8'hA5, ack_error=0, done exactly 320 clks after acceptance.
REQ-034 Read, CLK_DIV=4: slave returns 8'h3C, addr=7'h55, rw=1 -> data_read_master=8'h3C, ack_error=0, sda released during the 9th data bit.
REQ-035 Address mismatch, CLK_DIV=4: addr=7'h2A -> ack_error=1, STOP issued, done 176 clks after acceptance, no data bits driven.
REQ-036 Start pulse while busy=1 -> ignored; the current transaction completes unchanged with a single done pulse.
REQ-037 rst pulse during ADDR bit 3 -> sda=z and scl=z in the same cycle, busy=0; a subsequent write to 7'h55 completes normally.
REQ-038 Protocol check over all tests: no sda edge while scl is high except START (falling) and STOP (rising).

Source files
------------

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master; every bit is four CLK_DIV-clk quarters,
// SDA/SCL are open-drain and only ever pulled low or released.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] data_write_master,
  output logic [7:0] data_read_master,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  inout  wire        sda,
  inout  wire        scl
);
  localparam int DW = $clog2(CLK_DIV);
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_NACK, STOP
  } state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] adr_q, dat_q, rx_q, rx_d, rd_q, rd_d;
  logic busy_q, busy_d, done_q, done_d, ack_q, ack_d;
  logic scl_low_q, scl_low_d, sda_low_q, sda_low_d;
  logic tick, accept, smp, last;
  assign sda = sda_low_q ? 1'b0 : 1'bz;
  assign scl = scl_low_q ? 1'b0 : 1'bz;
  assign data_read_master = rd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ack_error = ack_q;
  always_comb begin
    tick = div_q == DW'(CLK_DIV - 1);
    accept = state_q == IDLE && start;
    smp = tick && qtr_q == 2'd2;
    last = tick && qtr_q == 2'd3;
    div_d = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
    qtr_d = accept ? 2'd0 : tick ? qtr_q + 2'd1 : qtr_q;
    bit_d = bit_q;
    state_d = accept ? START : state_q;
    if (last) begin
      bit_d = (state_q inside {ADDR, WRITE_DATA, READ_DATA}) ? bit_q + 3'd1 : 3'd0;
      case (state_q)
        START:                state_d = ADDR;
        ADDR:                 state_d = bit_q == 3'd7 ? ADDR_ACK : ADDR;
        ADDR_ACK:             state_d = ack_q ? STOP : adr_q[0] ? READ_DATA : WRITE_DATA;
        WRITE_DATA:           state_d = bit_q == 3'd7 ? WRITE_ACK : WRITE_DATA;
        READ_DATA:            state_d = bit_q == 3'd7 ? READ_NACK : READ_DATA;
        WRITE_ACK, READ_NACK: state_d = STOP;
        default:              state_d = IDLE;
      endcase
    end
    // Line levels follow the quarter being entered, so they leave the flops glitch-free
    scl_low_d = state_d == IDLE ? 1'b0 :
                state_d == START ? qtr_d == 2'd3 :
                state_d == STOP ? qtr_d == 2'd0 :
                (qtr_d == 2'd0 || qtr_d == 2'd3);
    sda_low_d = state_d == START ? qtr_d != 2'd0 :
                state_d == STOP ? qtr_d < 2'd2 :
                state_d == ADDR ? !adr_q[~bit_d] :
                state_d == WRITE_DATA ? !dat_q[~bit_d] : 1'b0;
    ack_d = accept ? 1'b0 : (smp && (state_q == ADDR_ACK || state_q == WRITE_ACK)) ? ack_q | sda : ack_q;
    rx_d = (smp && state_q == READ_DATA) ? {rx_q[6:0], sda} : rx_q;
    rd_d = (last && state_q == READ_DATA && bit_q == 3'd7) ? rx_q : rd_q;
    done_d = last && state_q == STOP;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      qtr_q <= 2'd0;
      bit_q <= 3'd0;
      adr_q <= 8'h00;
      dat_q <= 8'h00;
      rx_q <= 8'h00;
      rd_q <= 8'h00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ack_q <= 1'b0;
      scl_low_q <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      qtr_q <= qtr_d;
      bit_q <= bit_d;
      if (accept) begin
        adr_q <= {addr, rw};
        dat_q <= data_write_master;
      end
      rx_q <= rx_d;
      rd_q <= rd_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ack_q <= ack_d;
      scl_low_q <= scl_low_d;
      sda_low_q <= sda_low_d;
    end
  end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: scoreboard bench with a behavioural I2C slave at 7'h55 and bus pull-ups
module tb_i2c_master;
  localparam int CLK_DIV = 4;
  localparam logic [6:0] SLV = 7'h55;
  logic clk = 1'b0;
  logic rst, start, rw;
  logic [6:0] addr;
  logic [7:0] data_write_master;
  wire [7:0] data_read_master;
  wire busy, done, ack_error;
  wire sda, scl;
  pullup (sda);
  pullup (scl);
  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw),
    .data_write_master(data_write_master), .data_read_master(data_read_master),
    .busy(busy), .done(done), .ack_error(ack_error), .sda(sda), .scl(scl)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] rd;
    logic ack;
    int lat;
    logic rw;
    logic [7:0] wr;
  } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  int start_cnt = 0, stop_cnt = 0, scl_rise = 0, done_cnt = 0, rx_cnt = 0;
  logic [7:0] exp_rd = 8'h00;
  logic s_low = 1'b0, s_act = 1'b0, s_rd = 1'b0, s_match = 1'b0, s_ack9 = 1'b0;
  logic [7:0] s_sh = 8'h00, s_rx = 8'h00, s_tx = 8'h3C;
  int s_bit = 0, s_ph = 0;
  assign sda = s_low ? 1'b0 : 1'bz;
  // Any SDA edge with SCL high is a START or STOP; extra ones show up in the per-transaction counts
  always @(negedge sda) if (scl === 1'b1) begin
    start_cnt++;
    s_act = 1'b1; s_bit = 0; s_ph = 0; s_low = 1'b0; s_ack9 = 1'b0;
  end
  always @(posedge sda) if (scl === 1'b1) begin
    stop_cnt++;
    s_act = 1'b0;
  end
  always @(posedge scl) begin
    scl_rise++;
    if (s_act) begin
      if (s_bit < 8) s_sh = {s_sh[6:0], sda};
      else if (s_ph == 1) s_ack9 = sda;
      s_bit++;
    end
  end
  always @(negedge scl) if (s_act) begin
    #1;
    s_low = 1'b0;
    if (s_bit == 8) begin
      if (s_ph == 0) begin
        s_match = s_sh[7:1] == SLV;
        s_rd = s_sh[0];
        s_low = s_match;
      end else if (!s_rd) begin
        s_rx = s_sh;
        rx_cnt++;
        s_low = 1'b1;
      end
    end else if (s_bit == 9) begin
      s_bit = 0;
      s_ph++;
      if (!s_match || s_ph > 1) s_act = 1'b0;
      else if (s_rd) s_low = !s_tx[7];
    end else if (s_ph == 1 && s_rd && s_bit > 0) s_low = !s_tx[7 - s_bit];
  end
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic test_txn(input logic [6:0] a, input logic r, input logic [7:0] d, input int poke);
    exp_t e;
    int n, s0, p0, r0, x0;
    e.ack = a != SLV;
    e.lat = (e.ack ? 11 : 20) * 4 * CLK_DIV;
    if (r && !e.ack) exp_rd = 8'h3C;
    e.rd = exp_rd;
    e.rw = r;
    e.wr = d;
    sb.push_back(e);
    s0 = start_cnt; p0 = stop_cnt; r0 = scl_rise; x0 = rx_cnt;
    @(negedge clk);
    addr = a; rw = r; data_write_master = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_after_accept: got %b want 1", busy); end
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == poke) begin addr = 7'h2A; rw = 1'b1; data_write_master = 8'h00; start = 1'b1; end
      if (n == poke + 1) start = 1'b0;
      if (done === 1'b1) break;
    end
    e = sb.pop_front();
    vectors++;
    if (n != e.lat) begin miscompares++; $display("FAIL latency: got %0d want %0d", n, e.lat); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_at_done: got %b want 0", busy); end
    vectors++;
    if (ack_error !== e.ack) begin miscompares++; $display("FAIL ack_error: got %b want %b", ack_error, e.ack); end
    vectors++;
    if (data_read_master !== e.rd) begin miscompares++; $display("FAIL read_data: got %h want %h", data_read_master, e.rd); end
    vectors++;
    if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin
      miscompares++;
      $display("FAIL start_stop: got %0d/%0d want 1/1", start_cnt - s0, stop_cnt - p0);
    end
    vectors++;
    if (scl_rise - r0 != (e.ack ? 10 : 19)) begin
      miscompares++;
      $display("FAIL scl_pulses: got %0d want %0d", scl_rise - r0, e.ack ? 10 : 19);
    end
    vectors++;
    if (rx_cnt - x0 != ((!e.rw && !e.ack) ? 1 : 0)) begin
      miscompares++;
      $display("FAIL slave_rx_count: got %0d want %0d", rx_cnt - x0, (!e.rw && !e.ack) ? 1 : 0);
    end
    if (!e.rw && !e.ack) begin
      vectors++;
      if (s_rx !== e.wr) begin miscompares++; $display("FAIL slave_rx: got %h want %h", s_rx, e.wr); end
    end
    if (e.rw && !e.ack) begin
      vectors++;
      if (s_ack9 !== 1'b1) begin miscompares++; $display("FAIL master_nack: got %b want 1", s_ack9); end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; addr = 7'h00; rw = 1'b0; data_write_master = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, ack_error} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {busy, done, ack_error}); end
    vectors++;
    if (data_read_master !== 8'h00) begin miscompares++; $display("FAIL reset_rdata: got %h want 00", data_read_master); end
    vectors++;
    if ({sda, scl} !== 2'b11) begin miscompares++; $display("FAIL reset_bus: got %b want 11", {sda, scl}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    test_txn(SLV, 1'b0, 8'hA5, -1);
  endtask

  task automatic test_read;
    test_txn(SLV, 1'b1, 8'h00, -1);
  endtask

  task automatic test_addr_nack;
    test_txn(7'h2A, 1'b0, 8'hFF, -1);
    repeat (20) @(negedge clk);
    vectors++;
    if (ack_error !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_hold: got ack=%b busy=%b want ack=1 busy=0", ack_error, busy);
    end
  endtask

  task automatic test_busy_start;
    int d0;
    d0 = done_cnt;
    test_txn(SLV, 1'b0, 8'h5A, 100);
    repeat (40) @(negedge clk);
    vectors++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_ignored: got done=%0d busy=%b want done=1 busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_abort;
    int p0, d0;
    p0 = stop_cnt; d0 = done_cnt;
    @(negedge clk);
    addr = SLV; rw = 1'b0; data_write_master = 8'hC3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({sda, scl, busy} !== 3'b110) begin miscompares++; $display("FAIL abort_release: got %b want 110", {sda, scl, busy}); end
    exp_rd = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    vectors++;
    if (stop_cnt != p0 || done_cnt != d0 || busy !== 1'b0 || data_read_master !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_quiet: got stops=%0d dones=%0d busy=%b rd=%h want 0 0 0 00",
               stop_cnt - p0, done_cnt - d0, busy, data_read_master);
    end
    test_txn(SLV, 1'b0, 8'h96, -1);
  endtask

  task automatic test_back_to_back;
    logic [6:0] ta [4] = '{7'h55, 7'h55, 7'h55, 7'h2A};
    logic       tr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] td [4] = '{8'h00, 8'hFF, 8'h11, 8'h5A};
    for (int i = 0; i < 4; i++) test_txn(ta[i], tr[i], td[i], -1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_busy_start();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
